bp_cfg_shadow_regfile: RTL and testbench
========================================

# bp_cfg_shadow_regfile

Multi-core runtime configuration register file on the config bus. It holds `num_core_p` banks of `num_regs_p` registers each, and every bank has a shadow copy and an active copy. Writes land in the shadow copy, and an explicit commit moves the whole bank to the active copy in one cycle. Reads return data through a two-entry response buffer. It sits between the host config link and the per-core control inputs (freeze and mode fields), and replaces fixed per-configuration parameter sets with values that can be reprogrammed at runtime.

## Interface
Parameters:
- `num_core_p`, 1, number of core banks; must be 1 to 64.
- `num_regs_p`, 8, registers per bank; must be 2 or more.
- `cfg_core_width_p`, 8, width of the core-select field.
- `cfg_addr_width_p`, 16, width of the address field.
- `cfg_data_width_p`, 32, register width.

Ports:
- `clk_i`  in  1  single clock.
- `reset_n_i`  in  1  asynchronous, active-low reset (decided).
- `cfg_v_i`  in  1  request valid.
- `cfg_ready_o`  out  1  request ready; a request is accepted on `cfg_v_i & cfg_ready_o`.
- `cfg_w_i`  in  1  1 = write, 0 = read.
- `cfg_core_i`  in  `cfg_core_width_p`  target bank; all-ones means broadcast.
- `cfg_addr_i`  in  `cfg_addr_width_p`  MSB is the bank select (1 = shadow, 0 = active, reads only); the low bits are the register index.
- `cfg_data_i`  in  `cfg_data_width_p`  write data.
- `resp_v_o`  out  1  read response valid.
- `resp_yumi_i`  in  1  consumer pops the response; legal only while `resp_v_o` is high.
- `resp_data_o`  out  `cfg_data_width_p`  read data.
- `resp_err_o`  out  1  the read was illegal; data is zero.
- `active_regs_o`  out  `num_core_p*num_regs_p*cfg_data_width_p`  active registers, flattened with core-major ordering.
- `freeze_o`  out  `num_core_p`  bit 0 of active register 0 for each core.

## Operation
- Index `idx = cfg_addr_i[cfg_addr_width_p-2:0]`.
- Write with `idx < num_regs_p`: the shadow register of the target bank is updated. For broadcast, every bank's shadow register is updated.
- Write with `idx == num_regs_p` (commit address):
  - `data[0]=1`: commit, shadow copied to active for the whole bank (all banks on broadcast).
  - `data[0]=0`: discard, active copied to shadow.
- Write with `idx > num_regs_p`, or with a non-broadcast core ≥ `num_core_p`: the write is ignored silently.
- Read with `idx < num_regs_p` and a valid non-broadcast core: returns the shadow or active register, as selected by the address MSB, with `resp_err_o=0`.
- Any other read (broadcast, out-of-range core, or `idx ≥ num_regs_p`): `resp_data_o=0`, `resp_err_o=1`.
- Writes produce no response.
- Response buffer: 2-entry FIFO.
  - `cfg_ready_o = ~full`, registered, with no bypass from `resp_yumi_i`.
  - While full, `cfg_ready_o` is low for writes as well as reads.
- Reset values of outputs and state:
  - Register 0 of every bank, both copies = 1 (frozen); all other registers = 0.
  - FIFO empty: `resp_v_o=0`, `resp_err_o=0`, `resp_data_o=0`.
  - `cfg_ready_o=1`.
- Reset asserted mid-operation: all state returns to the reset values asynchronously, and buffered responses are dropped.

## Timing
- A write accepted at edge N is visible in shadow at N+1. A read of the shadow issued at N+1 returns the new value.
- A commit accepted at edge N: `active_regs_o` and `freeze_o` change at N+1, all registers of the bank together, with no partial-update cycle.
- A read accepted at edge N: the response is captured at N and `resp_v_o=1` from N+1. The data is the register value before any update at edge N; only one request can be accepted per cycle, so no same-cycle conflict exists.
- Push and pop in the same cycle: occupancy is unchanged, and `cfg_ready_o` follows the resulting occupancy on the next cycle.
- FIFO full at 2 entries: `cfg_ready_o=0` the cycle after the second push, and it returns to 1 the cycle after a pop.
- Responses return in request order.

## Structure
- The package `bp_cfg_pkg` holds:
  - typedef `bp_cfg_req_s` with fields w, core, addr, data;
  - typedef `bp_cfg_resp_s` with fields data, err;
  - constant `bp_cfg_commit_idx(num_regs)`;
  - constant `bp_cfg_bcast_core` = all-ones.
- Sub-module: `bsg_two_fifo`, which provides the response buffer.
- Bank registers are a generate loop over cores, each bank holding a shadow array and an active array.

## Test plan
- After reset release: `freeze_o` = all-ones, `cfg_ready_o=1`, `resp_v_o=0`. Reading active register 0 of core 0 returns 1 with err=0.
- Write core 0 reg 3 = 0xA5A5_0001, then read the active copy → 0, and read the shadow copy → 0xA5A5_0001. Commit with data=1 → `active_regs_o` core 0 reg 3 = 0xA5A5_0001 exactly one cycle after acceptance.
- Broadcast write reg 0 = 0, then broadcast commit with `num_core_p=4` → `freeze_o` goes from 0xF to 0x0 in a single cycle.
- Write shadow core 1 reg 2 = 7, then discard (data=0), then read shadow → 0.
- Three reads back-to-back with `resp_yumi_i=0` → two accepted; `cfg_ready_o=0` after the second. Pop one → the third is accepted, and responses come back in order.
- Read with `idx = num_regs_p+1` → err=1, data=0. Assert reset while the FIFO holds 2 entries → `resp_v_o=0` immediately and all registers return to their reset values.

Source files
------------

// File: rtl/bp_cfg_pkg.sv
// rtl/bp_cfg_pkg.sv - shared types and constants for the shadow/active config register file
package bp_cfg_pkg;

    localparam int bp_cfg_core_width_gp = 8;
    localparam int bp_cfg_addr_width_gp = 16;
    localparam int bp_cfg_data_width_gp = 32;

    localparam logic [bp_cfg_core_width_gp-1:0] bp_cfg_bcast_core = '1;

    typedef struct packed {
        logic                            w;
        logic [bp_cfg_core_width_gp-1:0] core;
        logic [bp_cfg_addr_width_gp-1:0] addr;
        logic [bp_cfg_data_width_gp-1:0] data;
    } bp_cfg_req_s;

    typedef struct packed {
        logic [bp_cfg_data_width_gp-1:0] data;
        logic                            err;
    } bp_cfg_resp_s;

    // The commit/discard slot sits just past the last real register.
    function automatic int bp_cfg_commit_idx(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// rtl/bsg_two_fifo.sv - two-entry response FIFO with registered ready and zeroed idle output
module bsg_two_fifo #(
    parameter int width_p = 33
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] r_mem [2];
    logic               r_head;
    logic               r_tail;
    logic [1:0]         r_cnt;
    logic               w_push;
    logic               w_pop;

    assign w_push  = v_i & ready_o;
    assign w_pop   = yumi_i & v_o;
    // Ready depends only on stored occupancy; a same-cycle pop does not open it.
    assign ready_o = (r_cnt != 2'd2);
    assign v_o     = (r_cnt != 2'd0);
    assign data_o  = v_o ? r_mem[r_head] : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= data_i;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/bp_cfg_shadow_regfile.sv
// rtl/bp_cfg_shadow_regfile.sv - per-core shadow/active config registers with bank commit and buffered reads
module bp_cfg_shadow_regfile
    import bp_cfg_pkg::*;
#(
    parameter int num_core_p       = 1,
    parameter int num_regs_p       = 8,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic                                              cfg_v_i,
    output logic                                              cfg_ready_o,
    input  logic                                              cfg_w_i,
    input  logic [cfg_core_width_p-1:0]                       cfg_core_i,
    input  logic [cfg_addr_width_p-1:0]                       cfg_addr_i,
    input  logic [cfg_data_width_p-1:0]                       cfg_data_i,
    output logic                                              resp_v_o,
    input  logic                                              resp_yumi_i,
    output logic [cfg_data_width_p-1:0]                       resp_data_o,
    output logic                                              resp_err_o,
    output logic [num_core_p*num_regs_p*cfg_data_width_p-1:0] active_regs_o,
    output logic [num_core_p-1:0]                             freeze_o
);

    localparam int DW  = cfg_data_width_p;
    localparam int CW  = cfg_core_width_p;
    localparam int IW  = cfg_addr_width_p - 1;
    localparam int RW  = $clog2(num_regs_p);
    localparam int CIW = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    localparam logic [IW-1:0] lp_nregs      = IW'(num_regs_p);
    localparam logic [IW-1:0] lp_commit_idx = IW'(bp_cfg_commit_idx(num_regs_p));
    localparam logic [CW:0]   lp_ncore      = (CW+1)'(num_core_p);

    logic [IW-1:0]  w_idx;
    logic [RW-1:0]  w_ridx;
    logic [CIW-1:0] w_rcore;
    logic           w_shadow_sel;
    logic           w_bcast;
    logic           w_core_ok;
    logic           w_accept;
    logic           w_reg_wr;
    logic           w_commit_wr;
    logic           w_rd;
    logic           w_rd_ok;
    logic [DW-1:0]  w_rd_data;
    logic [DW-1:0]  w_sh_rd [num_core_p];
    logic [DW-1:0]  w_ac_rd [num_core_p];

    assign w_idx        = cfg_addr_i[IW-1:0];
    assign w_ridx       = w_idx[RW-1:0];
    assign w_rcore      = cfg_core_i[CIW-1:0];
    assign w_shadow_sel = cfg_addr_i[cfg_addr_width_p-1];
    assign w_bcast      = &cfg_core_i;
    assign w_core_ok    = ~w_bcast & ({1'b0, cfg_core_i} < lp_ncore);

    assign w_accept    = cfg_v_i & cfg_ready_o;
    assign w_reg_wr    = w_accept & cfg_w_i & (w_idx < lp_nregs);
    assign w_commit_wr = w_accept & cfg_w_i & (w_idx == lp_commit_idx);
    assign w_rd        = w_accept & ~cfg_w_i;
    assign w_rd_ok     = w_core_ok & (w_idx < lp_nregs);

    for (genvar c = 0; c < num_core_p; c++) begin : g_bank
        logic [DW-1:0] r_shadow [num_regs_p];
        logic [DW-1:0] r_active [num_regs_p];
        logic          w_sel;

        // Out-of-range non-broadcast cores match no bank, so such writes vanish.
        assign w_sel = w_bcast | (cfg_core_i == CW'(c));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                for (int i = 0; i < num_regs_p; i++) begin
                    if (i == 0) begin
                        r_shadow[i] <= DW'(1);
                        r_active[i] <= DW'(1);
                    end else begin
                        r_shadow[i] <= '0;
                        r_active[i] <= '0;
                    end
                end
            end else if (w_sel) begin
                if (w_reg_wr) begin
                    r_shadow[w_ridx] <= cfg_data_i;
                end else if (w_commit_wr) begin
                    if (cfg_data_i[0]) begin
                        r_active <= r_shadow;
                    end else begin
                        r_shadow <= r_active;
                    end
                end
            end
        end

        assign w_sh_rd[c]  = r_shadow[w_ridx];
        assign w_ac_rd[c]  = r_active[w_ridx];
        assign freeze_o[c] = r_active[0][0];

        for (genvar r = 0; r < num_regs_p; r++) begin : g_flat
            assign active_regs_o[(c*num_regs_p+r)*DW +: DW] = r_active[r];
        end
    end

    // Illegal reads still occupy a FIFO slot so responses stay in request order.
    assign w_rd_data = !w_rd_ok      ? '0 :
                       w_shadow_sel  ? w_sh_rd[w_rcore] : w_ac_rd[w_rcore];

    bsg_two_fifo #(
        .width_p (DW + 1)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ready_o   (cfg_ready_o),
        .data_i    ({~w_rd_ok, w_rd_data}),
        .v_i       (w_rd),
        .v_o       (resp_v_o),
        .data_o    ({resp_err_o, resp_data_o}),
        .yumi_i    (resp_yumi_i)
    );

endmodule

// File: tb/tb_bp_cfg_shadow_regfile.sv
// tb/tb_bp_cfg_shadow_regfile.sv - directed self-checking bench for bp_cfg_shadow_regfile
module tb_bp_cfg_shadow_regfile;

    localparam int NC = 4;
    localparam int NR = 8;
    localparam int DW = 32;

    logic               clk;
    logic               reset_n_i;
    logic               cfg_v_i;
    logic               cfg_ready_o;
    logic               cfg_w_i;
    logic [7:0]         cfg_core_i;
    logic [15:0]        cfg_addr_i;
    logic [31:0]        cfg_data_i;
    logic               resp_v_o;
    logic               resp_yumi_i;
    logic [31:0]        resp_data_o;
    logic               resp_err_o;
    logic [NC*NR*DW-1:0] active_regs_o;
    logic [NC-1:0]      freeze_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_act [NC][NR];

    bp_cfg_shadow_regfile #(
        .num_core_p       (NC),
        .num_regs_p       (NR),
        .cfg_core_width_p (8),
        .cfg_addr_width_p (16),
        .cfg_data_width_p (DW)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .cfg_v_i       (cfg_v_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_w_i       (cfg_w_i),
        .cfg_core_i    (cfg_core_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_data_i    (cfg_data_i),
        .resp_v_o      (resp_v_o),
        .resp_yumi_i   (resp_yumi_i),
        .resp_data_o   (resp_data_o),
        .resp_err_o    (resp_err_o),
        .active_regs_o (active_regs_o),
        .freeze_o      (freeze_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NC*NR*DW-1:0] exp_vec();
        logic [NC*NR*DW-1:0] v;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                v[(c*NR+r)*DW +: DW] = m_act[c][r];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                m_act[c][r] = (r == 0) ? 32'd1 : 32'd0;
    endtask

    task automatic send(input logic w, input logic [7:0] core, input logic [15:0] addr,
                        input logic [31:0] data);
        int n;
        @(negedge clk);
        cfg_v_i = 1'b1; cfg_w_i = w; cfg_core_i = core; cfg_addr_i = addr; cfg_data_i = data;
        n = 0;
        while (!cfg_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready_o) begin
            checks++; errors++;
            $display("FAIL send_ready_timeout got ready=%0b required ready=1", cfg_ready_o);
        end
        @(posedge clk);
        #1 cfg_v_i = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] core, input logic [15:0] addr,
                           output logic [31:0] d, output logic e);
        int n;
        send(1'b0, core, addr, 32'h0);
        n = 0;
        while (!resp_v_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp_v_o) begin
            checks++; errors++;
            $display("FAIL read_resp_timeout got resp_v=%0b required resp_v=1", resp_v_o);
        end
        d = resp_data_o;
        e = resp_err_o;
        @(negedge clk);
        resp_yumi_i = 1'b1;
        @(posedge clk);
        #1 resp_yumi_i = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        resp_yumi_i = 1'b1;
        @(posedge clk);
        #1 resp_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        model_reset();
        checks++; if (freeze_o !== 4'hF) begin errors++; $display("FAIL rst_freeze got %h required %h", freeze_o, 4'hF); end
        checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b required 1", cfg_ready_o); end
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rst_resp_v got %b required 0", resp_v_o); end
        checks++; if (resp_data_o !== 32'h0 || resp_err_o !== 1'b0) begin errors++; $display("FAIL rst_resp_out got %h/%b required 0/0", resp_data_o, resp_err_o); end
        checks++; if (active_regs_o !== exp_vec()) begin errors++; $display("FAIL rst_active_regs got %h required %h", active_regs_o, exp_vec()); end
        do_read(8'd0, 16'h0000, d, e);
        checks++; if (d !== 32'd1 || e !== 1'b0) begin errors++; $display("FAIL rst_read_active0 got %h/%b required 1/0", d, e); end
    endtask

    task automatic test_write_commit();
        logic [31:0] d;
        logic        e;
        send(1'b1, 8'd0, 16'h8003, 32'hA5A5_0001);
        do_read(8'd0, 16'h0003, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL wc_read_active got %h/%b required 0/0", d, e); end
        do_read(8'd0, 16'h8003, d, e);
        checks++; if (d !== 32'hA5A5_0001 || e !== 1'b0) begin errors++; $display("FAIL wc_read_shadow got %h/%b required a5a50001/0", d, e); end
        checks++; if (active_regs_o !== exp_vec()) begin errors++; $display("FAIL wc_pre_commit got %h required %h", active_regs_o, exp_vec()); end
        send(1'b1, 8'd0, 16'h0008, 32'h1);
        m_act[0][3] = 32'hA5A5_0001;
        checks++; if (active_regs_o[3*DW +: DW] !== 32'hA5A5_0001) begin errors++; $display("FAIL wc_commit_reg3 got %h required a5a50001", active_regs_o[3*DW +: DW]); end
        checks++; if (active_regs_o !== exp_vec()) begin errors++; $display("FAIL wc_commit_all got %h required %h", active_regs_o, exp_vec()); end
        checks++; if (freeze_o !== 4'hF) begin errors++; $display("FAIL wc_freeze got %h required f", freeze_o); end
    endtask

    task automatic test_broadcast();
        send(1'b1, 8'hFF, 16'h8000, 32'h0);
        checks++; if (freeze_o !== 4'hF) begin errors++; $display("FAIL bc_freeze_pre got %h required f", freeze_o); end
        @(negedge clk);
        cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_core_i = 8'hFF; cfg_addr_i = 16'h0008; cfg_data_i = 32'h1;
        checks++; if (freeze_o !== 4'hF || cfg_ready_o !== 1'b1) begin errors++; $display("FAIL bc_before_edge got freeze=%h ready=%b required f/1", freeze_o, cfg_ready_o); end
        @(posedge clk);
        #1 cfg_v_i = 1'b0;
        for (int c = 0; c < NC; c++) m_act[c][0] = 32'h0;
        checks++; if (freeze_o !== 4'h0) begin errors++; $display("FAIL bc_freeze_post got %h required 0", freeze_o); end
        checks++; if (active_regs_o !== exp_vec()) begin errors++; $display("FAIL bc_active got %h required %h", active_regs_o, exp_vec()); end
    endtask

    task automatic test_discard();
        logic [31:0] d;
        logic        e;
        send(1'b1, 8'd1, 16'h8002, 32'h7);
        do_read(8'd1, 16'h8002, d, e);
        checks++; if (d !== 32'h7 || e !== 1'b0) begin errors++; $display("FAIL dc_shadow_written got %h/%b required 7/0", d, e); end
        send(1'b1, 8'd1, 16'h0008, 32'h0);
        do_read(8'd1, 16'h8002, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL dc_shadow_restored got %h/%b required 0/0", d, e); end
        checks++; if (active_regs_o !== exp_vec()) begin errors++; $display("FAIL dc_active got %h required %h", active_regs_o, exp_vec()); end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        logic        e;
        send(1'b1, 8'd0, 16'h8001, 32'h66);
        send(1'b1, 8'd0, 16'h0009, 32'h1);
        checks++; if (active_regs_o !== exp_vec()) begin errors++; $display("FAIL il_idx9_write got %h required %h", active_regs_o, exp_vec()); end
        do_read(8'd0, 16'h8001, d, e);
        checks++; if (d !== 32'h66 || e !== 1'b0) begin errors++; $display("FAIL il_shadow_kept got %h/%b required 66/0", d, e); end
        send(1'b1, 8'd5, 16'h8001, 32'h55);
        do_read(8'd1, 16'h8001, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL il_core5_alias got %h/%b required 0/0", d, e); end
        do_read(8'd5, 16'h8001, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL il_read_core5 got %h/%b required 0/1", d, e); end
        do_read(8'd0, 16'h8009, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL il_read_idx9 got %h/%b required 0/1", d, e); end
        do_read(8'd0, 16'h0008, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL il_read_idx8 got %h/%b required 0/1", d, e); end
        do_read(8'hFF, 16'h8003, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL il_read_bcast got %h/%b required 0/1", d, e); end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 8'd2, 16'h8001, 32'h11);
        send(1'b1, 8'd3, 16'h8004, 32'h22);
        @(negedge clk);
        cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_core_i = 8'd0; cfg_addr_i = 16'h8003;
        @(posedge clk); #1;
        checks++; if (cfg_ready_o !== 1'b1 || resp_v_o !== 1'b1) begin errors++; $display("FAIL b2b_one got ready=%b v=%b required 1/1", cfg_ready_o, resp_v_o); end
        @(negedge clk);
        cfg_core_i = 8'd2; cfg_addr_i = 16'h8001;
        @(posedge clk); #1;
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b required 0", cfg_ready_o); end
        @(negedge clk);
        cfg_core_i = 8'd3; cfg_addr_i = 16'h8004;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cfg_ready_o !== 1'b0 || resp_data_o !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_stall got ready=%b data=%h required 0/a5a50001", cfg_ready_o, resp_data_o); end
        @(negedge clk);
        resp_yumi_i = 1'b1;
        @(posedge clk);
        #1 resp_yumi_i = 1'b0;
        checks++; if (cfg_ready_o !== 1'b1 || resp_data_o !== 32'h11) begin errors++; $display("FAIL b2b_after_pop got ready=%b data=%h required 1/11", cfg_ready_o, resp_data_o); end
        @(posedge clk);
        #1 cfg_v_i = 1'b0;
        checks++; if (cfg_ready_o !== 1'b0 || resp_data_o !== 32'h11) begin errors++; $display("FAIL b2b_third_accept got ready=%b data=%h required 0/11", cfg_ready_o, resp_data_o); end
        pop();
        checks++; if (resp_data_o !== 32'h22 || resp_err_o !== 1'b0 || cfg_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_third_data got %h/%b ready=%b required 22/0/1", resp_data_o, resp_err_o, cfg_ready_o); end
        pop();
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b required 0", resp_v_o); end
    endtask

    task automatic test_push_pop();
        send(1'b0, 8'd0, 16'h8003, 32'h0);
        @(negedge clk);
        cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_core_i = 8'd2; cfg_addr_i = 16'h8001; resp_yumi_i = 1'b1;
        @(posedge clk);
        #1 begin cfg_v_i = 1'b0; resp_yumi_i = 1'b0; end
        checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 32'h11 || cfg_ready_o !== 1'b1) begin errors++; $display("FAIL pp_same_cycle got v=%b data=%h ready=%b required 1/11/1", resp_v_o, resp_data_o, cfg_ready_o); end
        pop();
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL pp_drained got %b required 0", resp_v_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        e;
        send(1'b0, 8'd0, 16'h8003, 32'h0);
        send(1'b0, 8'd2, 16'h8001, 32'h0);
        checks++; if (cfg_ready_o !== 1'b0 || resp_v_o !== 1'b1) begin errors++; $display("FAIL rm_full got ready=%b v=%b required 0/1", cfg_ready_o, resp_v_o); end
        @(negedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        model_reset();
        checks++; if (resp_v_o !== 1'b0 || cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rm_fifo got v=%b ready=%b required 0/1", resp_v_o, cfg_ready_o); end
        checks++; if (freeze_o !== 4'hF || active_regs_o !== exp_vec()) begin errors++; $display("FAIL rm_regs got freeze=%h active=%h required f/%h", freeze_o, active_regs_o, exp_vec()); end
        @(negedge clk);
        reset_n_i = 1'b1;
        do_read(8'd0, 16'h8003, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rm_shadow3 got %h/%b required 0/0", d, e); end
        do_read(8'd1, 16'h8000, d, e);
        checks++; if (d !== 32'h1 || e !== 1'b0) begin errors++; $display("FAIL rm_shadow0 got %h/%b required 1/0", d, e); end
    endtask

    initial begin
        reset_n_i   = 1'b0;
        cfg_v_i     = 1'b0;
        cfg_w_i     = 1'b0;
        cfg_core_i  = 8'd0;
        cfg_addr_i  = 16'h0;
        cfg_data_i  = 32'h0;
        resp_yumi_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        test_reset();
        test_write_commit();
        test_broadcast();
        test_discard();
        test_illegal();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
